// File: rtl/lsu_datamem.sv
// lsu_datamem: handshaked MEM-stage data memory with byte-lane stores and RV load extension.
module lsu_datamem #(
  parameter int    DM_ADDRESS = 9,
  parameter int    DATA_W     = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_fault
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int DEPTH = 2 ** (DM_ADDRESS - OFS);
  localparam bit D64   = DATA_W == 64;

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("lsu_datamem: DATA_W must be 32 or 64");
  end

  typedef enum logic {IDLE, RESP} state_t;
  state_t state;

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [DATA_W-1:0]         rd_word, wsh, sh, up;
  logic signed [DATA_W-1:0]  sx;
  logic [DM_ADDRESS-OFS-1:0] idx;
  logic [OFS-1:0]            off, size_m, aoff, r_off;
  logic [NB-1:0]             be;
  logic [1:0]                lg, r_lg;
  logic [6:0]                sh_amt;
  logic                      accept, legal, mis, fault, wen, r_uns, r_zero;

  assign req_ready = reset_n & ((state == IDLE) | rsp_ready);
  assign rsp_valid = state == RESP;
  assign accept    = req_valid & req_ready;

  assign lg     = req_funct3[1:0];
  assign off    = req_addr[OFS-1:0];
  assign idx    = req_addr[DM_ADDRESS-1:OFS];
  assign size_m = OFS'((1 << lg) - 1);
  assign legal  = req_we ? (!req_funct3[2] && (lg != 2'd3 || D64))
                         : (req_funct3 != 3'b111 && (D64 || (req_funct3 != 3'b011 && req_funct3 != 3'b110)));
`ifdef MISALIGN_TRAP_EN
  assign mis  = |(off & size_m);
  assign aoff = off;
`else
  assign mis  = 1'b0;
  assign aoff = off & ~size_m;
`endif
  assign fault = !legal | mis;
  assign wen   = accept & req_we & !fault;
  assign be    = NB'(((1 << (1 << lg)) - 1) << aoff);
  assign wsh   = req_wdata << {aoff, 3'b000};

  assign sh        = rd_word >> {r_off, 3'b000};
  assign sh_amt    = 7'(DATA_W - (8 << r_lg));
  assign up        = sh << sh_amt;
  assign sx        = $signed(up) >>> sh_amt;
  assign rsp_rdata = r_zero ? '0 : r_uns ? up >> sh_amt : $unsigned(sx);

  always_ff @(posedge clk) begin
    if (accept) rd_word <= mem[idx];
    if (wen)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rsp_fault <= 1'b0;
      r_zero    <= 1'b1;
      r_off     <= '0;
      r_lg      <= '0;
      r_uns     <= 1'b0;
    end else if (accept) begin
      state     <= RESP;
      rsp_fault <= fault;
      r_zero    <= req_we | fault;
      r_off     <= aoff;
      r_lg      <= lg;
      r_uns     <= req_funct3[2];
    end else if (rsp_ready) begin
      state     <= IDLE;
    end
  end
endmodule

// File: tb/tb_lsu_datamem.sv
// tb_lsu_datamem: randomized and directed checks of lsu_datamem against a byte-array reference model.
module tb_lsu_datamem;
    logic        clk = 0, reset_n = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [8:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    int          n_vec = 0, n_err = 0;
    logic [7:0]  ref_mem [512];
    typedef struct packed {logic [31:0] d; logic f;} exp_t;
    exp_t        q [$];

    lsu_datamem dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic drive(input logic v, we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic rr);
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3; rsp_ready = rr;
        #1;
    endtask

    task automatic set_rst(input logic v);
        @(negedge clk);
        reset_n = v;
        #1;
    endtask

    // Byte-addressed reference: sizes, legality, alignment and extension straight from the access rules.
    task automatic model(input logic we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] d, output logic f);
        int nb, base;
        logic legal;
        logic [31:0] v;
        nb    = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
        f    = !legal || (int'(a) % nb != 0);
        base = int'(a);
`else
        f    = !legal;
        base = int'(a) - int'(a) % nb;
`endif
        d = 0;
        if (!f && we) begin
            for (int k = 0; k < nb; k++) ref_mem[base + k] = wd[8*k +: 8];
        end else if (!f) begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            d = v;
        end
    endtask

    // One request with rsp_ready held high; returns what the response cycle showed.
    task automatic xfer(input logic we, input logic [8:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic ok, output logic [31:0] d, output logic f);
        drive(1, we, a, wd, f3, 1);
        for (int i = 0; i < 20 && !req_ready; i++) drive(1, we, a, wd, f3, 1);
        drive(0, we, a, wd, f3, 1);
        ok = rsp_valid; d = rsp_rdata; f = rsp_fault;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 9'h40, 32'h1234_5678, 3'd2, 1);
            n_vec++;
            if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %b expected 0", req_ready); end
        end
        n_vec++;
        if ({rsp_valid, rsp_fault, rsp_rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_rsp got v=%b f=%b d=%h expected v=0 f=0 d=0", rsp_valid, rsp_fault, rsp_rdata);
        end
        drive(0, 0, 0, 0, 0, 1);
        reset_n = 1;
    endtask

    task automatic init_mem;
        logic ok, f;
        logic [31:0] d, wd;
        for (int w = 0; w < 128; w++) begin
            wd = $urandom;
            model(1, 9'(w * 4), wd, 3'd2, d, f);
            xfer(1, 9'(w * 4), wd, 3'd2, ok, d, f);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic f;
        model(1, 9'h10, 32'hDEAD_BEEF, 3'd2, d, f);
        drive(1, 1, 9'h10, 32'hDEAD_BEEF, 3'd2, 1);
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_sw_ready got %b expected 1", req_ready); end
        drive(1, 0, 9'h10, 0, 3'd2, 1);
        n_vec++;
        if ({rsp_valid, rsp_fault, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_sw_rsp got v=%b f=%b d=%h r=%b expected v=1 f=0 d=0 r=1", rsp_valid, rsp_fault, rsp_rdata, req_ready);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL b2b_lw_rsp got v=%b f=%b d=%h expected v=1 f=0 d=deadbeef", rsp_valid, rsp_fault, rsp_rdata);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_single_rsp got %b expected 0", rsp_valid); end
    endtask

    task automatic test_subword;
        logic ok, f;
        logic [31:0] d;
        logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd5, 3'd2};
        logic [8:0]  as  [6] = '{9'h13, 9'h13, 9'h10, 9'h22, 9'h22, 9'h20};
        logic [31:0] exs [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h8000_0000,
                                 32'hFFFF_8001, 32'h0000_8001, 32'h8001_5678};
        model(1, 9'h10, 0, 3'd2, d, f);             xfer(1, 9'h10, 0, 3'd2, ok, d, f);
        model(1, 9'h13, 32'h80, 3'd0, d, f);        xfer(1, 9'h13, 32'h80, 3'd0, ok, d, f);
        model(1, 9'h20, 32'h1234_5678, 3'd2, d, f); xfer(1, 9'h20, 32'h1234_5678, 3'd2, ok, d, f);
        model(1, 9'h22, 32'h8001, 3'd1, d, f);      xfer(1, 9'h22, 32'h8001, 3'd1, ok, d, f);
        for (int i = 0; i < 6; i++) begin
            xfer(0, as[i], 0, f3s[i], ok, d, f);
            n_vec++;
            if ({ok, f, d} !== {1'b1, 1'b0, exs[i]}) begin
                n_err++;
                $display("FAIL subword_load%0d got v=%b f=%b d=%h expected v=1 f=0 d=%h", i, ok, f, d, exs[i]);
            end
        end
    endtask

    task automatic test_misalign;
        logic ok, f, ef;
        logic [31:0] d, ed, wd;
        logic [8:0]  a;
        logic [2:0]  f3;
        logic        we;
        model(0, 9'h11, 0, 3'd2, ed, ef);
        xfer(0, 9'h11, 0, 3'd2, ok, d, f);
        n_vec++;
        if ({ok, f, d} !== {1'b1, ef, ed}) begin
            n_err++;
            $display("FAIL misalign_lw got v=%b f=%b d=%h expected v=1 f=%b d=%h", ok, f, d, ef, ed);
        end
        for (int i = 0; i < 12; i++) begin
            we = i[0];
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            a  = 9'($urandom) | 9'd1;
            wd = $urandom;
            model(we, a, wd, f3, ed, ef);
            xfer(we, a, wd, f3, ok, d, f);
            n_vec++;
            if ({ok, f, d} !== {1'b1, ef, ed}) begin
                n_err++;
                $display("FAIL misalign_%0d we=%b a=%h f3=%0d got v=%b f=%b d=%h expected v=1 f=%b d=%h", i, we, a, f3, ok, f, d, ef, ed);
            end
            model(0, a & 9'h1FC, 0, 3'd2, ed, ef);
            xfer(0, a & 9'h1FC, 0, 3'd2, ok, d, f);
            n_vec++;
            if ({ok, f, d} !== {1'b1, ef, ed}) begin
                n_err++;
                $display("FAIL misalign_word%0d got v=%b f=%b d=%h expected v=1 f=%b d=%h", i, ok, f, d, ef, ed);
            end
        end
    endtask

    task automatic test_backpressure;
        logic ok, f, ef;
        logic [31:0] d, e0, eb;
        eb = $urandom;
        model(0, 9'h30, 0, 3'd2, e0, ef);
        drive(1, 0, 9'h30, 0, 3'd2, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 9'h34, eb, 3'd2, 0);
            n_vec++;
            if ({req_ready, rsp_valid, rsp_fault, rsp_rdata} !== {1'b0, 1'b1, 1'b0, e0}) begin
                n_err++;
                $display("FAIL stall%0d got r=%b v=%b f=%b d=%h expected r=0 v=1 f=0 d=%h", i, req_ready, rsp_valid, rsp_fault, rsp_rdata, e0);
            end
        end
        drive(1, 1, 9'h34, eb, 3'd2, 1);
        n_vec++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {1'b1, 1'b1, e0}) begin
            n_err++;
            $display("FAIL release got r=%b v=%b d=%h expected r=1 v=1 d=%h", req_ready, rsp_valid, rsp_rdata, e0);
        end
        model(1, 9'h34, eb, 3'd2, d, f);
        drive(1, 0, 9'h34, 0, 3'd2, 1);
        n_vec++;
        if ({req_ready, rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL queued_sw_rsp got r=%b v=%b f=%b d=%h expected r=1 v=1 f=0 d=0", req_ready, rsp_valid, rsp_fault, rsp_rdata);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, eb}) begin
            n_err++;
            $display("FAIL queued_lw_rsp got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_rdata, eb);
        end
        xfer(0, 9'h30, 0, 3'd2, ok, d, f);
        n_vec++;
        if ({ok, d} !== {1'b1, e0}) begin n_err++; $display("FAIL stall_no_write got v=%b d=%h expected v=1 d=%h", ok, d, e0); end
    endtask

    task automatic test_reset_mid;
        logic ok, f, ef;
        logic [31:0] d, e;
        model(0, 9'h40, 0, 3'd2, e, ef);
        drive(1, 0, 9'h40, 0, 3'd2, 0);
        set_rst(0);
        n_vec++;
        if ({req_ready, rsp_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_held got r=%b v=%b expected r=0 v=1", req_ready, rsp_valid);
        end
        drive(1, 1, 9'h40, ~e, 3'd2, 0);
        n_vec++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL rst_mid_drop got r=%b v=%b d=%h expected r=0 v=0 d=0", req_ready, rsp_valid, rsp_rdata);
        end
        drive(0, 0, 0, 0, 0, 1);
        set_rst(1);
        xfer(0, 9'h40, 0, 3'd2, ok, d, f);
        n_vec++;
        if ({ok, f, d} !== {1'b1, 1'b0, e}) begin
            n_err++;
            $display("FAIL rst_mid_no_write got v=%b f=%b d=%h expected v=1 f=0 d=%h", ok, f, d, e);
        end
    endtask

    task automatic test_random;
        localparam int N = 600;
        logic v, rr, we, ef;
        logic [8:0]  a;
        logic [31:0] wd, ed;
        logic [2:0]  f3;
        for (int i = 0; i < N; i++) begin
            v  = (i < N - 3) && ($urandom_range(0, 3) != 0);
            rr = (i >= N - 3) || ($urandom_range(0, 3) != 0);
            we = 1'($urandom);
            a  = 9'($urandom);
            wd = $urandom;
            f3 = 3'($urandom_range(0, 7));
            drive(v, we, a, wd, f3, rr);
            n_vec++;
            if (rsp_valid !== (q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_valid%0d got %b expected %b", i, rsp_valid, q.size() != 0);
            end
            n_vec++;
            if (req_ready !== (q.size() == 0 || rr)) begin
                n_err++;
                $display("FAIL rand_ready%0d got %b expected %b", i, req_ready, q.size() == 0 || rr);
            end
            if (q.size() != 0) begin
                n_vec++;
                if ({rsp_fault, rsp_rdata} !== {q[0].f, q[0].d}) begin
                    n_err++;
                    $display("FAIL rand_rsp%0d got f=%b d=%h expected f=%b d=%h", i, rsp_fault, rsp_rdata, q[0].f, q[0].d);
                end
                if (rr) void'(q.pop_front());
            end
            if (v && req_ready) begin
                model(we, a, wd, f3, ed, ef);
                q.push_back('{d: ed, f: ef});
            end
        end
    endtask

    initial begin
        test_reset;
        init_mem;
        test_back_to_back;
        test_subword;
        test_misalign;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
